eye_center_finder: RTL and testbench

- Downstream consumer of the per-tap error counter.
- Takes one packed vector of per-delay-tap error counts on a strobe.
- Scans the taps sequentially and finds the widest contiguous run of "good" taps, meaning taps whose count is at or below a threshold.
- Reports the centre tap of that run, which the IDELAY control logic loads as the optimum sampling tap.

---
 rtl/eye_center_finder.sv | 165 ++++++++++++++++
 tb/tb_eye_center_finder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/eye_center_finder.sv
`default_nettype none
// ============================================================================
// Module   : eye_center_finder
// Purpose  : Takes one packed vector of per-delay-tap error counts, scans the
//            taps one per cycle, finds the widest contiguous run of good taps
//            (count <= THRESHOLD, earliest run wins ties) and reports that
//            run's centre tap and width.
// Revision : 1.0 - initial release
// ============================================================================
module eye_center_finder #(
  parameter  int COUNT_WIDTH = 8,
  parameter  int DELAY_TAPS  = 4,
  parameter  int THRESHOLD   = 0,
  localparam int TAP_WIDTH   = (DELAY_TAPS > 1) ? $clog2(DELAY_TAPS) : 1
) (
  input  logic                              CLK,
  input  logic                              RSTN,
  input  logic                              I_STB,
  input  logic [DELAY_TAPS*COUNT_WIDTH-1:0] I_DAT,
  output logic                              O_BUSY,
  output logic                              O_STB,
  output logic                              O_VALID,
  output logic [TAP_WIDTH-1:0]              O_TAP,
  output logic [TAP_WIDTH:0]                O_WIDTH
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [TAP_WIDTH-1:0]   C_LAST  = TAP_WIDTH'(DELAY_TAPS - 1);
  localparam logic [COUNT_WIDTH-1:0] C_THRESH = COUNT_WIDTH'(THRESHOLD);

  logic [1:0]                        r_state;
  logic [1:0]                        w_next;
  logic [DELAY_TAPS*COUNT_WIDTH-1:0] r_shadow;
  logic [TAP_WIDTH-1:0]              r_k;       // tap being fetched
  logic                              r_eval;    // a fetched tap is waiting in r_good
  logic                              r_good;    // good flag of tap r_ek
  logic                              r_last;    // r_ek is the last tap
  logic [TAP_WIDTH-1:0]              r_ek;      // index of the tap being evaluated
  logic [TAP_WIDTH-1:0]              r_cur_start;
  logic [TAP_WIDTH:0]                r_cur_len;
  logic [TAP_WIDTH-1:0]              r_best_start;
  logic [TAP_WIDTH:0]                r_best_len;
  logic                              r_valid;
  logic [TAP_WIDTH-1:0]              r_tap;
  logic [TAP_WIDTH:0]                r_width;

  logic [COUNT_WIDTH-1:0]            w_tap;
  logic                              w_tap_good;
  logic [TAP_WIDTH:0]                w_len_inc;
  logic [TAP_WIDTH-1:0]              w_open_start;
  logic                              w_close;
  logic [TAP_WIDTH:0]                w_close_len;
  logic [TAP_WIDTH-1:0]              w_close_start;
  logic                              w_upd;
  logic [TAP_WIDTH:0]                w_fin_len;
  logic [TAP_WIDTH-1:0]              w_fin_start;
  logic [TAP_WIDTH:0]                w_ctr;

  // State register; reset aborts any scan in progress.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode and status outputs.
  always_comb begin
    w_next = r_state;
    O_BUSY = 1'b0;
    O_STB  = 1'b0;
    case (r_state)
      S_IDLE: if (I_STB) w_next = S_SCAN;
      S_SCAN: begin
        O_BUSY = 1'b1;
        if (r_eval && r_last) w_next = S_DONE;
      end
      S_DONE: begin
        O_BUSY = 1'b1;
        O_STB  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Run bookkeeping for the tap held in r_good, including closing the run
  // on a bad tap or on the last tap, and the final centre computation.
  always_comb begin
    w_tap         = r_shadow[r_k*COUNT_WIDTH +: COUNT_WIDTH];
    w_tap_good    = (w_tap <= C_THRESH);
    w_len_inc     = r_cur_len + 1'b1;
    w_open_start  = (r_cur_len == '0) ? r_ek : r_cur_start;
    w_close       = !r_good || r_last;
    w_close_len   = r_good ? w_len_inc : r_cur_len;
    w_close_start = r_good ? w_open_start : r_cur_start;
    w_upd         = w_close && (w_close_len > r_best_len);
    w_fin_len     = w_upd ? w_close_len : r_best_len;
    w_fin_start   = w_upd ? w_close_start : r_best_start;
    w_ctr         = {1'b0, w_fin_start} + ((w_fin_len - 1'b1) >> 1);
  end

  // Datapath: capture on strobe, fetch one tap per cycle, track runs one
  // cycle behind the fetch, and load the result registers on entry to DONE.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_shadow     <= '0;
      r_k          <= '0;
      r_eval       <= 1'b0;
      r_good       <= 1'b0;
      r_last       <= 1'b0;
      r_ek         <= '0;
      r_cur_start  <= '0;
      r_cur_len    <= '0;
      r_best_start <= '0;
      r_best_len   <= '0;
      r_valid      <= 1'b0;
      r_tap        <= '0;
      r_width      <= '0;
    end else if (r_state == S_IDLE) begin
      if (I_STB) begin
        r_shadow     <= I_DAT;
        r_k          <= '0;
        r_eval       <= 1'b0;
        r_good       <= 1'b0;
        r_last       <= 1'b0;
        r_ek         <= '0;
        r_cur_start  <= '0;
        r_cur_len    <= '0;
        r_best_start <= '0;
        r_best_len   <= '0;
      end
    end else if (r_state == S_SCAN) begin
      r_good <= w_tap_good;
      r_last <= (r_k == C_LAST);
      r_ek   <= r_k;
      r_eval <= 1'b1;
      if (r_k != C_LAST) r_k <= r_k + 1'b1;
      if (r_eval) begin
        if (r_good) begin
          r_cur_start <= w_open_start;
          r_cur_len   <= w_len_inc;
        end else begin
          r_cur_len   <= '0;
        end
        if (w_upd) begin
          r_best_start <= w_close_start;
          r_best_len   <= w_close_len;
        end
        if (r_last) begin
          r_valid <= (w_fin_len != '0);
          r_width <= w_fin_len;
          r_tap   <= (w_fin_len == '0) ? '0 : w_ctr[TAP_WIDTH-1:0];
        end
      end
    end
  end

  assign O_VALID = r_valid;
  assign O_TAP   = r_tap;
  assign O_WIDTH = r_width;

endmodule
`default_nettype wire

// File: tb/tb_eye_center_finder.sv
`default_nettype none
// ============================================================================
// Module   : tb_eye_center_finder
// Purpose  : Self-checking bench for eye_center_finder. Two instances
//            (THRESHOLD 0 and 2) share the stimulus; a window-search model
//            predicts every output cycle by cycle, and directed vectors pin
//            hand-computed results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eye_center_finder;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        I_STB = 1'b0;
  logic [31:0] I_DAT = '0;

  logic [1:0]  busy, stb, valid;
  logic [1:0]  tap [2];
  logic [2:0]  wid [2];

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  // model state per instance: countdown to result, pending and held results
  int m_cnt   [2] = '{0, 0};
  int m_pend  [2] = '{0, 0};
  int m_res   [2] = '{0, 0};
  int th      [2] = '{0, 2};

  always #5 CLK = ~CLK;

  eye_center_finder #(.COUNT_WIDTH(8), .DELAY_TAPS(4), .THRESHOLD(0)) dut0 (
    .CLK(CLK), .RSTN(RSTN), .I_STB(I_STB), .I_DAT(I_DAT),
    .O_BUSY(busy[0]), .O_STB(stb[0]), .O_VALID(valid[0]),
    .O_TAP(tap[0]), .O_WIDTH(wid[0]));

  eye_center_finder #(.COUNT_WIDTH(8), .DELAY_TAPS(4), .THRESHOLD(2)) dut2 (
    .CLK(CLK), .RSTN(RSTN), .I_STB(I_STB), .I_DAT(I_DAT),
    .O_BUSY(busy[1]), .O_STB(stb[1]), .O_VALID(valid[1]),
    .O_TAP(tap[1]), .O_WIDTH(wid[1]));

  // Best window by exhaustive search: encoded as width*256 + centre, 0 if none.
  function automatic int best_code(logic [31:0] d, int t);
    int bw = 0;
    int bs = 0;
    for (int s = 0; s < 4; s++) begin
      int len = 0;
      for (int j = s; j < 4; j++) begin
        if (int'(d[8*j +: 8]) <= t && len == j - s) len++;
      end
      if (len > bw) begin
        bw = len;
        bs = s;
      end
    end
    return (bw == 0) ? 0 : bw * 256 + bs + (bw - 1) / 2;
  endfunction

  // Model: a strobe in idle starts a 6-cycle busy period, the result shows
  // in its final cycle and holds afterwards.
  always @(posedge CLK or negedge RSTN) begin
    for (int i = 0; i < 2; i++) begin
      if (!RSTN) begin
        m_cnt[i]  <= 0;
        m_pend[i] <= 0;
        m_res[i]  <= 0;
      end else if (m_cnt[i] != 0) begin
        m_cnt[i] <= m_cnt[i] - 1;
        if (m_cnt[i] == 2) m_res[i] <= m_pend[i];
      end else if (I_STB) begin
        m_cnt[i]  <= 6;
        m_pend[i] <= best_code(I_DAT, th[i]);
      end
    end
  end

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge CLK) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("busy[%0d]", i), int'(busy[i]), int'(m_cnt[i] != 0));
        check($sformatf("stb[%0d]", i), int'(stb[i]), int'(m_cnt[i] == 1));
        check($sformatf("valid[%0d]", i), int'(valid[i]), int'(m_res[i] != 0));
        check($sformatf("width[%0d]", i), int'(wid[i]), m_res[i] / 256);
        check($sformatf("tap[%0d]", i), int'(tap[i]), m_res[i] % 256);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy[0] && n < 50) begin
      tick();
      n++;
    end
    if (busy[0]) check("idle_timeout", 1, 0);
  endtask

  // Strobe one vector and check latency plus the hand-computed result of dut0.
  task automatic run_vec(string name, logic [31:0] d, int ev, int ew, int et);
    int n = 0;
    wait_idle();
    I_STB = 1'b1;
    I_DAT = d;
    tick();
    n = 1;
    I_STB = 1'b0;
    while (!stb[0] && n < 20) begin
      tick();
      n++;
    end
    check({name, "_latency"}, n, 6);
    check({name, "_valid"}, int'(valid[0]), ev);
    check({name, "_width"}, int'(wid[0]), ew);
    check({name, "_tap"}, int'(tap[0]), et);
    tick();
  endtask

  initial begin
    int nstb;
    repeat (3) tick();
    check("rst_busy", int'(busy[0]), 0);
    check("rst_width", int'(wid[0]), 0);
    RSTN = 1'b1;
    started = 1'b1;
    tick();

    // model self-pins
    check("model_a", best_code(32'h07000005, 0), 2 * 256 + 1);
    check("model_b", best_code(32'h03020100, 2), 3 * 256 + 1);

    run_vec("t1", 32'h07000005, 1, 2, 1);
    run_vec("t2a", 32'h00000000, 1, 4, 1);
    run_vec("t2b", 32'h01010101, 0, 0, 0);
    run_vec("t3a", 32'h00FF00FF, 1, 1, 1);
    run_vec("t3b", 32'h000000FF, 1, 3, 2);

    // busy drop: second strobe two cycles later must be ignored
    wait_idle();
    I_STB = 1'b1; I_DAT = 32'h07000005;
    tick();
    I_STB = 1'b0;
    tick();
    I_STB = 1'b1; I_DAT = 32'h00000000;
    tick();
    I_STB = 1'b0;
    nstb = 0;
    for (int c = 0; c < 12; c++) begin
      if (stb[0]) begin
        nstb++;
        check("t4_width", int'(wid[0]), 2);
        check("t4_tap", int'(tap[0]), 1);
      end
      tick();
    end
    check("t4_stb_count", nstb, 1);
    run_vec("t4b", 32'h00000000, 1, 4, 1);

    // reset mid-scan
    wait_idle();
    I_STB = 1'b1; I_DAT = 32'h00000000;
    tick();
    I_STB = 1'b0;
    tick();
    tick();
    RSTN = 1'b0;
    #1;
    check("t5_busy", int'(busy[0]), 0);
    check("t5_stb", int'(stb[0]), 0);
    check("t5_valid", int'(valid[0]), 0);
    check("t5_width", int'(wid[0]), 0);
    check("t5_tap", int'(tap[0]), 0);
    tick();
    tick();
    RSTN = 1'b1;
    nstb = 0;
    for (int c = 0; c < 10; c++) begin
      if (stb[0] || stb[1]) nstb++;
      tick();
    end
    check("t5_no_stb", nstb, 0);
    run_vec("t5b", 32'h07000005, 1, 2, 1);

    // threshold 2 on the second instance
    run_vec("t6", 32'h03020100, 1, 1, 0);
    check("t6_th2_valid", int'(valid[1]), 1);
    check("t6_th2_width", int'(wid[1]), 3);
    check("t6_th2_tap", int'(tap[1]), 1);

    repeat (3) tick();
    started = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
